// File: rtl/zero_sched_pkg.sv
// zero_sched_pkg
//   Shared types and constants for the zero_sched multi-cycle zero detector.
//   - state_t   : controller states (IDLE, SCAN, DONE)
//   - req_id_t  : requester identity (REQ_A = ALU flags, REQ_B = branch unit)
//   - SLICE_W   : width of the single NOR zero-detect slice
//   - arbitrate : round-robin pick between the two requesters
package zero_sched_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // A lone requester always wins; on a tie the port that was not served
  // last wins, so neither requester can starve the other.
  function automatic req_id_t arbitrate(input logic    req_a,
                                        input logic    req_b,
                                        input req_id_t last_grant);
    req_id_t pick;
    if (req_a && req_b) begin
      pick = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      pick = REQ_B;
    end else begin
      pick = REQ_A;
    end
    return pick;
  endfunction

endpackage

// File: rtl/zero_sched_nor16.sv
// nor16
//   16-input NOR zero-detect slice shared by both requesters.
//   Ports:
//     a : 16-bit slice of the operand under test
//     y : 1 when every bit of a is zero
module nor16 (
  input  logic [15:0] a,
  output logic        y
);

  assign y = ~|a;

endmodule

// File: rtl/zero_sched.sv
// zero_sched
//   Multi-cycle zero detector and round-robin arbiter. Port A (ALU flags)
//   and port B (CBZ/CBNZ branch unit) share one nor16 slice. The winning
//   operand is captured, then scanned one 16-bit slice per cycle, stopping
//   at the first non-zero slice. The result is tagged with its owner.
//   Ports:
//     clk            : rising-edge clock
//     reset          : synchronous, active-low reset
//     req_a, data_a  : requester A level request and operand
//     req_b, data_b  : requester B level request and operand
//     gnt_a, gnt_b   : one-cycle pulse in the first SCAN cycle after capture
//     busy           : high while in SCAN or DONE
//     done           : one-cycle result-valid pulse
//     done_id        : owner of the last result (0 = A, 1 = B), held
//     zero           : 1 iff the last captured operand was all-zero, held
module zero_sched
  import zero_sched_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int SLICES = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             zero
);

  localparam int              CNT_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Control state
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             acc_q,     acc_d;
  req_id_t          last_q,    last_d;
  logic             gnt_a_q,   gnt_a_d;
  logic             gnt_b_q,   gnt_b_d;
  logic             zero_q,    zero_d;
  req_id_t          done_id_q, done_id_d;

  // Captured operand and its owner (data path, not reset)
  logic [SLICES-1:0][SLICE_W-1:0] op_q, op_d;
  req_id_t                        owner_q, owner_d;

  logic [SLICE_W-1:0] slice;
  logic               nor_out;
  req_id_t            winner;

  // Slice mux -> nor16 is the critical path into next-state/zero logic.
  assign slice = op_q[cnt_q];

  nor16 u_nor16 (
    .a (slice),
    .y (nor_out)
  );

  assign winner = arbitrate(req_a, req_b, last_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    last_d    = last_q;
    zero_d    = zero_q;
    done_id_d = done_id_q;
    op_d      = op_q;
    owner_d   = owner_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          op_d    = (winner == REQ_B) ? data_b : data_a;
          owner_d = winner;
          last_d  = winner;
          cnt_d   = '0;
          acc_d   = 1'b1;
          gnt_a_d = (winner == REQ_A);
          gnt_b_d = (winner == REQ_B);
          state_d = SCAN;
        end
      end

      SCAN: begin
        // acc carries "every slice so far was zero"; a non-zero slice ends
        // the scan immediately since the answer can no longer be 1.
        acc_d = acc_q & nor_out;
        if (!nor_out || (cnt_q == CNT_LAST)) begin
          zero_d    = acc_q & nor_out;
          done_id_d = owner_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    owner_q <= owner_d;

    if (!reset) begin
      // last_grant starts at B so that A wins the first tie.
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= 1'b1;
      last_q    <= REQ_B;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      zero_q    <= 1'b0;
      done_id_q <= REQ_A;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      last_q    <= last_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      zero_q    <= zero_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_zero_sched.sv
module tb_zero_sched;

  localparam int WIDTH  = 64;
  localparam int SLICES = WIDTH / 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_a = 1'b0;
  logic [WIDTH-1:0] data_a = '0;
  logic             req_b = 1'b0;
  logic [WIDTH-1:0] data_b = '0;
  logic             gnt_a, gnt_b, busy, done, done_id, zero;

  int checks = 0;
  int errors = 0;

  // Reference: which port was served last (0 = A, 1 = B).
  logic last_m = 1'b1;

  zero_sched #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_a   (req_a),
    .data_a  (data_a),
    .req_b   (req_b),
    .data_b  (data_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wa;
    logic        wb;
    logic [63:0] da;
    logic [63:0] db;
    logic        exp_b;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle (after the capture edge) in which done should appear.
  function automatic int expected_latency(input logic [63:0] d);
    for (int k = 0; k < SLICES; k++) begin
      if (d[16*k +: 16] != 16'h0) return k + 2;
    end
    return SLICES + 1;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    chk_b("rst_gnt_a", gnt_a, 1'b0);
    chk_b("rst_gnt_b", gnt_b, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_zero", zero, 1'b0);
    chk_b("rst_done_id", done_id, 1'b0);
    tick();
    reset = 1'b1;
    last_m = 1'b1;
  endtask

  // One full operation, entered and left at #1 into an IDLE cycle.
  task automatic do_round(input logic want_a, input logic want_b,
                          input logic [63:0] da, input logic [63:0] db,
                          input logic keep, input logic scramble,
                          output logic got_b, output int lat_o);
    logic        win_b;
    logic [63:0] op;
    int          exp_lat;
    int          c;
    logic        seen;
    if (want_a && !req_a) begin req_a = 1'b1; data_a = da; end
    if (want_b && !req_b) begin req_b = 1'b1; data_b = db; end
    if (req_a && req_b) win_b = ~last_m;
    else                win_b = req_b;
    op      = win_b ? data_b : data_a;
    exp_lat = expected_latency(op);
    last_m  = win_b;

    tick();
    chk_b("gnt_a", gnt_a, ~win_b);
    chk_b("gnt_b", gnt_b, win_b);
    chk_b("gnt_excl", gnt_a & gnt_b, 1'b0);
    chk_b("busy_scan", busy, 1'b1);
    if (!keep) begin
      if (win_b) req_b = 1'b0; else req_a = 1'b0;
    end
    if (scramble) begin
      if (win_b) data_b = '1; else data_a = '1;
    end

    c = 1;
    seen = 1'b0;
    while (!seen && c < 12) begin
      tick();
      c++;
      if (done) seen = 1'b1;
      else begin
        chk_b("gnt_one_cycle", gnt_a | gnt_b, 1'b0);
        chk_b("busy_hold", busy, 1'b1);
      end
    end
    chk_b("done_seen", seen, 1'b1);
    chk_i("latency", c, exp_lat);
    chk_b("zero", zero, op == 64'h0);
    chk_b("done_id", done_id, win_b);
    chk_b("busy_done", busy, 1'b1);

    tick();
    chk_b("done_pulse", done, 1'b0);
    chk_b("busy_idle", busy, 1'b0);
    chk_b("zero_held", zero, op == 64'h0);
    chk_b("done_id_held", done_id, win_b);
    got_b = win_b;
    lat_o = c;
  endtask

  initial begin
    logic        got_b;
    int          lat;
    logic [63:0] rd;
    logic        fair_exp [4];
    int          pulses;

    // Table: runs straight after a reset, so A wins the first tie.
    vecs[0] = '{1'b1, 1'b0, 64'h0,                   64'h0,                   1'b0, 1'b1, 5};
    vecs[1] = '{1'b0, 1'b1, 64'h0,                   64'h0000_0000_0001_0000, 1'b1, 1'b0, 3};
    vecs[2] = '{1'b1, 1'b1, 64'h0000_0000_0000_0001, 64'h0,                   1'b0, 1'b0, 2};
    vecs[3] = '{1'b0, 1'b0, 64'h0,                   64'h0,                   1'b1, 1'b1, 5};
    vecs[4] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h0,                   1'b0, 1'b0, 5};
    vecs[5] = '{1'b0, 1'b1, 64'h0,                   64'h0000_0001_0000_0000, 1'b1, 1'b0, 4};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_round(vecs[i].wa, vecs[i].wb, vecs[i].da, vecs[i].db, 1'b0, 1'b0, got_b, lat);
      chk_b($sformatf("vec%0d_owner", i), got_b, vecs[i].exp_b);
      chk_b($sformatf("vec%0d_zero", i), zero, vecs[i].exp_zero);
      chk_i($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Tie straight after reset: A first, then the held B request.
    do_reset();
    do_round(1'b1, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, got_b, lat);
    chk_b("tie_first", got_b, 1'b0);
    chk_b("tie_first_zero", zero, 1'b1);
    do_round(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, got_b, lat);
    chk_b("tie_second", got_b, 1'b1);
    chk_b("tie_second_zero", zero, 1'b1);

    // Fairness: both requests held high across four operations.
    fair_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_round(1'b1, 1'b1, 64'h0, 64'h0, 1'b1, 1'b0, got_b, lat);
      chk_b($sformatf("fair%0d", i), got_b, fair_exp[i]);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();

    // Reset in the middle of a scan: result registers must be cleared and
    // no done pulse may appear.
    do_reset();
    do_round(1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, got_b, lat);
    req_a  = 1'b1;
    data_a = 64'h0;
    tick();
    chk_b("abort_gnt_a", gnt_a, 1'b1);
    req_a = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_b("abort_gnt_a0", gnt_a, 1'b0);
    chk_b("abort_gnt_b0", gnt_b, 1'b0);
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_done", done, 1'b0);
    chk_b("abort_zero", zero, 1'b0);
    chk_b("abort_done_id", done_id, 1'b0);
    reset  = 1'b1;
    last_m = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) pulses++;
    end
    chk_i("abort_no_done", pulses, 0);
    do_round(1'b0, 1'b1, 64'h0, 64'h0000_0000_0000_0100, 1'b0, 1'b0, got_b, lat);
    chk_b("after_abort_owner", got_b, 1'b1);
    chk_i("after_abort_lat", lat, 2);

    // Operand isolation: data_a goes all-ones after a zero capture.
    do_round(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, got_b, lat);
    chk_b("isolation_zero", zero, 1'b1);
    chk_i("isolation_lat", lat, 5);

    // Randomized traffic against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic wa, wb;
      logic [63:0] dra, drb;
      int ka, kb;
      wa  = 1'($urandom_range(0, 1));
      wb  = 1'($urandom_range(0, 1));
      if (!wa && !wb && !req_a && !req_b) wa = 1'b1;
      dra = {$urandom, $urandom};
      drb = {$urandom, $urandom};
      ka  = $urandom_range(0, SLICES);
      kb  = $urandom_range(0, SLICES);
      for (int s = 0; s < SLICES; s++) begin
        if (s < ka) dra[16*s +: 16] = 16'h0;
        if (s < kb) drb[16*s +: 16] = 16'h0;
      end
      rd = dra;
      do_round(wa, wb, rd, drb, 1'b0, 1'b0, got_b, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
